// File: rtl/ram_pkg.sv
// Shared constants and helpers for the single-port RAM family:
// read/write mode encodings, clear-FSM states and a byte-lane merge.
package ram_pkg;

  localparam int RW_WRITE_FIRST = 0;
  localparam int RW_READ_FIRST  = 1;
  localparam int RW_NO_CHANGE   = 2;

  localparam int BYTE_W = 8;

  // The merge works on a fixed maximum width; callers zero-extend their word
  // and truncate the result, which supports any DATA_WIDTH up to 256 bits.
  localparam int MERGE_MAX_BYTES = 32;
  localparam int MERGE_MAX_W     = MERGE_MAX_BYTES * BYTE_W;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } clear_state_e;

  function automatic logic [MERGE_MAX_W-1:0] byte_merge(
    input logic [MERGE_MAX_W-1:0]     old_word,
    input logic [MERGE_MAX_W-1:0]     new_word,
    input logic [MERGE_MAX_BYTES-1:0] be
  );
    logic [MERGE_MAX_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MERGE_MAX_BYTES; i++) begin
      if (be[i]) merged[i*BYTE_W +: BYTE_W] = new_word[i*BYTE_W +: BYTE_W];
    end
    return merged;
  endfunction

endpackage

// File: rtl/ram_clear_fsm.sv
// Post-reset clear sequencer: walks every address once, flagging init_busy
// until the last word has been zeroed.
module ram_clear_fsm
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 5,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  init_busy,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  localparam clear_state_e RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  clear_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    init_busy = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        init_busy = 1'b1;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = ST_RUN;
      end
      ST_RUN: begin
        init_busy = 1'b0;
      end
    endcase
  end

  assign clr_addr = cnt_q;

endmodule

// File: rtl/ram_sp_modes.sv
// Single-port synchronous RAM with selectable write/read collision mode,
// byte write enables, optional output register and post-reset clear sweep.
module ram_sp_modes
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int RW_MODE        = RW_NO_CHANGE,
  parameter bit OUT_REG        = 1'b0,
  parameter bit CLEAR_ON_RESET = 1'b1,
  localparam int NUM_BYTES     = DATA_WIDTH / BYTE_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [NUM_BYTES-1:0]  we,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  init_busy,
  output logic [DATA_WIDTH-1:0] mem_0
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  user_acc;
  logic                  user_wr;
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] merged_word;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_vld;
  logic [DATA_WIDTH-1:0] rd_data;

  logic [DATA_WIDTH-1:0] dout_p1;
  logic                  vld_p1;

  ram_clear_fsm #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_busy (init_busy),
    .clr_addr  (clr_addr)
  );

  assign user_acc    = en & ~init_busy;
  assign user_wr     = user_acc & (|we);
  assign old_word    = mem[address];
  assign merged_word = DATA_WIDTH'(byte_merge(MERGE_MAX_W'(old_word),
                                              MERGE_MAX_W'(din),
                                              MERGE_MAX_BYTES'(we)));

  // The sweep owns the write port while busy; nothing is written in reset.
  assign wr_en   = rst_n & (init_busy | user_wr);
  assign wr_addr = init_busy ? clr_addr : address;
  assign wr_data = init_busy ? '0 : merged_word;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign mem_0 = mem[0];

  assign rd_vld  = user_acc & (~(|we) | (RW_MODE != RW_NO_CHANGE));
  assign rd_data = ((|we) && (RW_MODE == RW_WRITE_FIRST)) ? merged_word : old_word;

  // Stage 1: array read / collision result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= rd_vld;
      if (rd_vld) dout_p1 <= rd_data;
    end
  end

  // Stage 2: optional output register
  generate
    if (OUT_REG) begin : g_out_reg
      logic [DATA_WIDTH-1:0] dout_p2;
      logic                  vld_p2;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_p2 <= '0;
          vld_p2  <= 1'b0;
        end else begin
          vld_p2 <= vld_p1;
          if (vld_p1) dout_p2 <= dout_p1;
        end
      end

      assign dout       = dout_p2;
      assign dout_valid = vld_p2;
    end else begin : g_no_out_reg
      assign dout       = dout_p1;
      assign dout_valid = vld_p1;
    end
  endgenerate

endmodule
